// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path:
// FSM states, opcode/funct values, ULA and mux select codes.
package mips_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ULA_W   = 3;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_RTYPE  = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_IEXEC  = 4'd9,
        ST_IWB    = 4'd10,
        ST_JUMP   = 4'd11
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_NOR = 6'b100111;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ULA_W-1:0] ULA_AND = 3'b000;
    localparam logic [ULA_W-1:0] ULA_OR  = 3'b001;
    localparam logic [ULA_W-1:0] ULA_ADD = 3'b010;
    localparam logic [ULA_W-1:0] ULA_NOR = 3'b011;
    localparam logic [ULA_W-1:0] ULA_SUB = 3'b110;
    localparam logic [ULA_W-1:0] ULA_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_RESULT = 2'b00;
    localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full datapath control word produced each cycle by the FSM
    typedef struct packed {
        logic             iord;
        logic             mem_write;
        logic             ir_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             ula_src_a;
        logic [1:0]       ula_src_b;
        logic [ULA_W-1:0] ula_control;
        logic             zero_imm;
        logic [1:0]       pc_src;
        logic             pc_en;
        logic             illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/alu_decoder.sv
// R-type funct to ULAControl map; valid is low for unsupported funct codes.
module alu_decoder
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] funct,
    output logic [ULA_W-1:0] ula_control,
    output logic             valid
);

    always_comb begin
        ula_control = ULA_ADD;
        valid       = 1'b1;
        case (OP_W'(funct))
            FN_ADD:  ula_control = ULA_ADD;
            FN_SUB:  ula_control = ULA_SUB;
            FN_AND:  ula_control = ULA_AND;
            FN_OR:   ula_control = ULA_OR;
            FN_NOR:  ula_control = ULA_NOR;
            FN_SLT:  ula_control = ULA_SLT;
            default: valid       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback over
// 3-5 cycles with ready-handshaked memory accesses.
module multicycle_control_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH  = 6,
    parameter bit          EXT_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] OP,
    input  logic [WIDTH-1:0] Funct,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [2:0]       ULAControl,
    output logic             ZeroImm,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             illegal_op,
    output logic [3:0]       state_o
);

    state_t           state;
    state_t           state_next;
    ctrl_t            ctrl;
    logic [OP_W-1:0]  op;
    logic [ULA_W-1:0] funct_ctl;
    logic             funct_ok;
    logic             is_mem;
    logic             is_branch;
    logic             is_bne;
    logic             is_iexec;

    assign op = OP_W'(OP);

    alu_decoder #(.WIDTH(WIDTH)) u_alu_decoder (
        .funct       (Funct),
        .ula_control (funct_ctl),
        .valid       (funct_ok)
    );

    // Opcode classes; extended opcodes only decode when EXT_EN is set
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
    assign is_bne    = EXT_EN && (op == OP_BNE);
    assign is_branch = (op == OP_BEQ) || is_bne;
    assign is_iexec  = (op == OP_ADDI) ||
                       (EXT_EN && ((op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ctrl       = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                ctrl.ula_src_b   = SRCB_FOUR;
                ctrl.ula_control = ULA_ADD;
                ctrl.pc_src      = PCSRC_RESULT;
                ctrl.ir_write    = mem_ready;
                ctrl.pc_en       = mem_ready;
                if (mem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl.ula_src_b   = SRCB_IMM_SH;
                ctrl.ula_control = ULA_ADD;
                state_next       = ST_FETCH;
                if (is_mem)                            state_next = ST_MEMADR;
                else if ((op == OP_RTYPE) && funct_ok) state_next = ST_RTYPE;
                else if (is_branch)                    state_next = ST_BRANCH;
                else if (is_iexec)                     state_next = ST_IEXEC;
                else if (op == OP_J)                   state_next = ST_JUMP;
                else                                   ctrl.illegal_op = 1'b1;
            end
            ST_MEMADR: begin
                ctrl.ula_src_a   = 1'b1;
                ctrl.ula_src_b   = SRCB_IMM;
                ctrl.ula_control = ULA_ADD;
                state_next       = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                ctrl.iord = 1'b1;
                if (mem_ready) state_next = ST_MEMWB;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                if (mem_ready) state_next = ST_FETCH;
            end
            ST_RTYPE: begin
                ctrl.ula_src_a   = 1'b1;
                ctrl.ula_src_b   = SRCB_B;
                ctrl.ula_control = funct_ctl;
                state_next       = ST_ALUWB;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.ula_src_a   = 1'b1;
                ctrl.ula_src_b   = SRCB_B;
                ctrl.ula_control = ULA_SUB;
                ctrl.pc_src      = PCSRC_ULAOUT;
                ctrl.pc_en       = is_bne ? ~Zero : Zero;
                state_next       = ST_FETCH;
            end
            ST_IEXEC: begin
                ctrl.ula_src_a   = 1'b1;
                ctrl.ula_src_b   = SRCB_IMM;
                ctrl.ula_control = ULA_ADD;
                if (EXT_EN) begin
                    case (op)
                        OP_ANDI: begin
                            ctrl.ula_control = ULA_AND;
                            ctrl.zero_imm    = 1'b1;
                        end
                        OP_ORI: begin
                            ctrl.ula_control = ULA_OR;
                            ctrl.zero_imm    = 1'b1;
                        end
                        OP_SLTI: ctrl.ula_control = ULA_SLT;
                        default: ctrl.ula_control = ULA_ADD;
                    endcase
                end
                state_next = ST_IWB;
            end
            ST_IWB: begin
                ctrl.reg_write = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
                state_next  = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
        // Reset forces a quiet datapath even though FETCH would otherwise strobe
        if (rst) ctrl = CTRL_IDLE;
    end

    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign RegDst     = ctrl.reg_dst;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign RegWrite   = ctrl.reg_write;
    assign ULASrcA    = ctrl.ula_src_a;
    assign ULASrcB    = ctrl.ula_src_b;
    assign ULAControl = ctrl.ula_control;
    assign ZeroImm    = ctrl.zero_imm;
    assign PCSrc      = ctrl.pc_src;
    assign PCEn       = ctrl.pc_en;
    assign illegal_op = ctrl.illegal_op;
    assign state_o    = 4'(state);

endmodule
